apb_master: RTL and testbench
=============================

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter ADDR_W, default 8, address width.
REQ-002 Parameter DATA_W, default 8, data width.
REQ-003 Parameter TIMEOUT, default 16, maximum ACCESS cycles before abort; 0 disables the timeout.
REQ-004 pclk  in  1  clock; all logic on rising edge.
REQ-005 prst  in  1  reset, synchronous, active-high.
REQ-006 cmd_valid  in  1  command request.
REQ-007 cmd_ready  out  1  command accepted when high with cmd_valid.
REQ-008 cmd_write  in  1  1=write, 0=read.
REQ-009 cmd_addr  in  ADDR_W  target address.
REQ-010 cmd_wdata  in  DATA_W  write data.
REQ-011 rsp_valid  out  1  response available.
REQ-012 rsp_ready  in  1  response consumed when high with rsp_valid.
REQ-013 rsp_rdata  out  DATA_W  read data; 0 for writes and aborts.
REQ-014 rsp_err  out  1  pslverr seen or timeout.
REQ-015 rsp_timeout  out  1  transfer aborted by timeout.
REQ-016 psel, penable, pwrite  out  1 each  APB control.
REQ-017 paddr  out  ADDR_W; pwdata  out  DATA_W  APB address and write data.
REQ-018 prdata  in  DATA_W; pready  in  1; pslverr  in  1  APB slave response.

Function
REQ-019 FSM states IDLE, SETUP, ACCESS; psel=0/penable=0 in IDLE, psel=1/penable=0 in SETUP, psel=1/penable=1 in ACCESS.
REQ-020 cmd_ready = (state==IDLE) && (!rsp_valid || rsp_ready), combinational.
REQ-021 Accept in cycle T: cmd fields registered to paddr/pwrite/pwdata; SETUP in T+1, ACCESS in T+2.
REQ-022 SETUP always moves to ACCESS after exactly one cycle.
REQ-023 ACCESS with pready=1: next cycle IDLE; rsp_valid=1; rsp_rdata=prdata if read, else 0; rsp_err=pslverr; rsp_timeout=0.
REQ-024 ACCESS with pready=0: stay in ACCESS; paddr, pwrite, pwdata, psel, penable unchanged; wait counter increments.
REQ-025 Wait counter clears on entry to ACCESS; when TIMEOUT!=0 and counter==TIMEOUT-1 with pready=0: next cycle IDLE, rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-026 pready and pslverr are ignored outside ACCESS; prdata is sampled only on read completion.
REQ-027 penable is low in the cycle after any completion or abort; no ACCESS->SETUP back-to-back (minimum 3 cycles per transfer).
REQ-028 rsp_valid and the response fields hold until rsp_ready; rsp_ready with rsp_valid clears rsp_valid next cycle unless a new completion occurs in that same cycle.
REQ-029 A response pending with rsp_ready=0 blocks new commands (cmd_ready=0).
REQ-030 paddr, pwrite and pwdata hold their last values in IDLE.

Reset
REQ-031 prst=1 at an edge: IDLE; psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, rsp_timeout and wait counter all 0.
REQ-032 Reset mid-transfer or with a response pending aborts the transfer and discards the response; no response is emitted for it.

Structure
REQ-033 Shared package apb_pkg holds typedef apb_state_e {IDLE, SETUP, ACCESS} and default width localparams.
REQ-034 Single module, no sub-module; wait counter width $clog2(TIMEOUT+1).

Verification
REQ-035 Write addr 8'h10 data 8'hA5, pready=1 -> psel at T+1, penable only at T+2; rsp_valid at T+3 with rsp_err=0, rsp_rdata=0.
REQ-036 Read addr 8'h22, prdata 8'h5C, 3 wait cycles -> APB signals stable for 3 cycles; rsp_rdata=8'h5C at completion+1.
REQ-037 Write with pslverr=1 at completion -> rsp_err=1, rsp_timeout=0.
REQ-038 TIMEOUT=16, pready held 0 -> abort after 16 ACCESS cycles; rsp_err=1, rsp_timeout=1, psel=0.
REQ-039 rsp_ready=0 for 5 cycles with cmd_valid=1 -> cmd_ready=0 throughout and response fields stable; command accepted in the same cycle rsp_ready rises.
REQ-040 prst asserted during ACCESS -> all outputs 0 next cycle, no rsp_valid.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB master slice.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;

  localparam int unsigned APB_ADDR_W  = 8;
  localparam int unsigned APB_DATA_W  = 8;
  localparam int unsigned APB_TIMEOUT = 16;

endpackage

// File: rtl/apb_master_if.sv
// Command/response handshake and APB bus signals of the APB master.
interface apb_master_if
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W = APB_ADDR_W,
  parameter int unsigned DATA_W = APB_DATA_W
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  psel, penable, pwrite, paddr, pwdata
  );

endinterface

// File: rtl/apb_master.sv
// Single-outstanding APB master: command in, one APB transfer, response out,
// with an optional ACCESS-phase timeout.
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = APB_ADDR_W,
  parameter int unsigned DATA_W  = APB_DATA_W,
  parameter int unsigned TIMEOUT = APB_TIMEOUT
) (
  input  logic        pclk,
  input  logic        prst,
  apb_master_if.master bus
);

  // Width is kept at least 1 so TIMEOUT=0 still elaborates.
  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  apb_state_e        state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              cmd_ready;

  assign cmd_ready = (state_q == IDLE) && (!rsp_valid_q || bus.rsp_ready);

  always_comb begin
    state_d       = state_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    wait_cnt_d    = wait_cnt_q;

    if (rsp_valid_q && bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready) begin
          state_d  = SETUP;
          psel_d   = 1'b1;
          pwrite_d = bus.cmd_write;
          paddr_d  = bus.cmd_addr;
          pwdata_d = bus.cmd_wdata;
        end
      end
      SETUP: begin
        state_d    = ACCESS;
        penable_d  = 1'b1;
        wait_cnt_d = '0;
      end
      ACCESS: begin
        if (bus.pready) begin
          state_d       = IDLE;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? '0 : bus.prdata;
          rsp_err_d     = bus.pslverr;
          rsp_timeout_d = 1'b0;
        end else if ((TIMEOUT != 0) && (wait_cnt_q == CNT_LAST)) begin
          state_d       = IDLE;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      state_q       <= IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      wait_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  assign bus.cmd_ready   = cmd_ready;
  assign bus.psel        = psel_q;
  assign bus.penable     = penable_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.paddr       = paddr_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed self-checking bench for apb_master (8-bit address/data, TIMEOUT=16).
module tb_apb_master;

  logic pclk = 1'b0;
  logic prst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  apb_master_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  apb_master #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(16)) dut (
    .pclk (pclk),
    .prst (prst),
    .bus  (bus)
  );

  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic test_reset();
    bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    bus.rsp_ready = 0; bus.prdata = '0; bus.pready = 0; bus.pslverr = 0;
    prst = 1;
    tick(); tick();
    checks++;
    if ({bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata} !== 19'h0) begin
      errors++; $display("FAIL reset_apb: got %h want 0",
        {bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata});
    end
    checks++;
    if ({bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout} !== 11'h0) begin
      errors++; $display("FAIL reset_rsp: got %h want 0",
        {bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout});
    end
    prst = 0;
    #1;
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_cmd_ready: got %b want 1", bus.cmd_ready);
    end
  endtask

  task automatic test_write();
    bus.cmd_valid = 1; bus.cmd_write = 1; bus.cmd_addr = 8'h10; bus.cmd_wdata = 8'hA5;
    bus.pready = 1; bus.prdata = 8'h77; bus.pslverr = 0;
    #1;
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL wr_accept: cmd_ready got %b want 1", bus.cmd_ready);
    end
    tick();
    bus.cmd_valid = 0;
    checks++;
    if ({bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata} !== {3'b101, 8'h10, 8'hA5}) begin
      errors++; $display("FAIL wr_setup: got %h want %h",
        {bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata}, {3'b101, 8'h10, 8'hA5});
    end
    tick();
    checks++;
    if ({bus.psel, bus.penable, bus.rsp_valid} !== 3'b110) begin
      errors++; $display("FAIL wr_access: psel/penable/rsp_valid got %b want 110",
        {bus.psel, bus.penable, bus.rsp_valid});
    end
    tick();
    checks++;
    if ({bus.psel, bus.penable, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata} !== {5'b00100, 8'h00}) begin
      errors++; $display("FAIL wr_rsp: got %h want %h",
        {bus.psel, bus.penable, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata}, {5'b00100, 8'h00});
    end
    checks++;
    if ({bus.pwrite, bus.paddr, bus.pwdata} !== {1'b1, 8'h10, 8'hA5}) begin
      errors++; $display("FAIL wr_idle_hold: got %h want %h",
        {bus.pwrite, bus.paddr, bus.pwdata}, {1'b1, 8'h10, 8'hA5});
    end
    bus.rsp_ready = 1;
    tick();
    bus.rsp_ready = 0;
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL wr_consume: rsp_valid got %b want 0", bus.rsp_valid);
    end
  endtask

  task automatic test_read_wait();
    bus.cmd_valid = 1; bus.cmd_write = 0; bus.cmd_addr = 8'h22; bus.cmd_wdata = 8'h3C;
    bus.pready = 0; bus.prdata = 8'hFF;
    tick();
    bus.cmd_valid = 0;
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata, bus.rsp_valid} !== {3'b110, 8'h22, 8'h3C, 1'b0}) begin
        errors++; $display("FAIL rd_wait%0d: got %h want %h", i,
          {bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata, bus.rsp_valid}, {3'b110, 8'h22, 8'h3C, 1'b0});
      end
      if (i < 2) tick();
    end
    bus.pready = 1; bus.prdata = 8'h5C;
    tick();
    bus.prdata = 8'h99;
    checks++;
    if ({bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata, bus.penable} !== {3'b100, 8'h5C, 1'b0}) begin
      errors++; $display("FAIL rd_rsp: got %h want %h",
        {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata, bus.penable}, {3'b100, 8'h5C, 1'b0});
    end
  endtask

  // Entered with the read response still pending and rsp_ready low.
  task automatic test_backpressure();
    bus.cmd_valid = 1; bus.cmd_write = 1; bus.cmd_addr = 8'h40; bus.cmd_wdata = 8'h0F;
    bus.pready = 1; bus.pslverr = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if ({bus.cmd_ready, bus.psel, bus.rsp_valid, bus.rsp_rdata} !== {3'b001, 8'h5C}) begin
        errors++; $display("FAIL bp_hold%0d: got %h want %h", i,
          {bus.cmd_ready, bus.psel, bus.rsp_valid, bus.rsp_rdata}, {3'b001, 8'h5C});
      end
      tick();
    end
    bus.rsp_ready = 1;
    #1;
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: cmd_ready got %b want 1", bus.cmd_ready);
    end
    tick();
    bus.rsp_ready = 0; bus.cmd_valid = 0;
    checks++;
    if ({bus.psel, bus.penable, bus.rsp_valid, bus.paddr} !== {3'b100, 8'h40}) begin
      errors++; $display("FAIL bp_accept: got %h want %h",
        {bus.psel, bus.penable, bus.rsp_valid, bus.paddr}, {3'b100, 8'h40});
    end
  endtask

  // Continues the write accepted in test_backpressure, completing with pslverr.
  task automatic test_slverr();
    tick();
    tick();
    checks++;
    if ({bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata} !== {3'b110, 8'h00}) begin
      errors++; $display("FAIL slverr_rsp: got %h want %h",
        {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata}, {3'b110, 8'h00});
    end
    bus.pslverr = 0;
  endtask

  // Response consumed in the same cycle the next command is accepted.
  task automatic test_back_to_back();
    bus.rsp_ready = 1; bus.cmd_valid = 1; bus.cmd_write = 1;
    bus.cmd_addr = 8'h55; bus.cmd_wdata = 8'h66; bus.pready = 1;
    tick();
    bus.cmd_valid = 0;
    checks++;
    if ({bus.psel, bus.penable, bus.rsp_valid, bus.paddr} !== {3'b100, 8'h55}) begin
      errors++; $display("FAIL b2b_setup: got %h want %h",
        {bus.psel, bus.penable, bus.rsp_valid, bus.paddr}, {3'b100, 8'h55});
    end
    bus.cmd_valid = 1; bus.cmd_addr = 8'h56;
    tick();
    tick();
    checks++;
    if ({bus.psel, bus.penable, bus.rsp_valid, bus.rsp_err} !== 4'b0010) begin
      errors++; $display("FAIL b2b_done: got %b want 0010",
        {bus.psel, bus.penable, bus.rsp_valid, bus.rsp_err});
    end
    tick();
    bus.cmd_valid = 0;
    checks++;
    if ({bus.psel, bus.penable, bus.paddr} !== {2'b10, 8'h56}) begin
      errors++; $display("FAIL b2b_second: got %h want %h",
        {bus.psel, bus.penable, bus.paddr}, {2'b10, 8'h56});
    end
    tick();
    tick();
    tick();
    bus.rsp_ready = 0;
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_drain: rsp_valid got %b want 0", bus.rsp_valid);
    end
  endtask

  task automatic test_timeout();
    int n;
    bus.cmd_valid = 1; bus.cmd_write = 0; bus.cmd_addr = 8'h33;
    bus.pready = 0; bus.prdata = 8'hAB;
    tick();
    bus.cmd_valid = 0;
    tick();
    n = 0;
    while (bus.penable && n < 40) begin
      n++;
      tick();
    end
    checks++;
    if (n !== 16) begin
      errors++; $display("FAIL to_cycles: ACCESS cycles got %0d want 16", n);
    end
    checks++;
    if ({bus.psel, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata} !== {4'b0111, 8'h00}) begin
      errors++; $display("FAIL to_rsp: got %h want %h",
        {bus.psel, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata}, {4'b0111, 8'h00});
    end
    bus.rsp_ready = 1;
    tick();
    bus.rsp_ready = 0;
  endtask

  task automatic test_reset_mid();
    bus.cmd_valid = 1; bus.cmd_write = 1; bus.cmd_addr = 8'h7E; bus.cmd_wdata = 8'hC3;
    bus.pready = 0;
    tick();
    bus.cmd_valid = 0;
    tick();
    tick();
    checks++;
    if ({bus.psel, bus.penable} !== 2'b11) begin
      errors++; $display("FAIL rst_mid_pre: psel/penable got %b want 11", {bus.psel, bus.penable});
    end
    prst = 1; bus.pready = 1;
    tick();
    prst = 0;
    checks++;
    if ({bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata, bus.rsp_valid,
         bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout} !== 30'h0) begin
      errors++; $display("FAIL rst_mid_out: got %h want 0",
        {bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata, bus.rsp_valid,
         bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout});
    end
    tick();
    tick();
    checks++;
    if ({bus.psel, bus.rsp_valid} !== 2'b00) begin
      errors++; $display("FAIL rst_mid_after: psel/rsp_valid got %b want 00", {bus.psel, bus.rsp_valid});
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_backpressure();
    test_slverr();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
